// File: rtl/exec_monitor_if.sv
// Bundle of control inputs and status outputs between the CPU-side driver and the
// execution monitor. The master drives arm/clear/CPU observations; the slave reports status.
interface exec_monitor_if #(
  parameter int PC_WIDTH    = 16,
  parameter int STATE_WIDTH = 3,
  parameter int CNT_WIDTH   = 32
);
  logic                   arm;
  logic                   clear;
  logic [PC_WIDTH-1:0]    pc;
  logic [STATE_WIDTH-1:0] cpu_state;
  logic                   mem_write;
  logic                   running;
  logic                   halted;
  logic                   timed_out;
  logic                   done;
  logic [CNT_WIDTH-1:0]   cycle_count;
  logic [CNT_WIDTH-1:0]   retired_count;
  logic [CNT_WIDTH-1:0]   mem_write_count;

  modport master (
    output arm, clear, pc, cpu_state, mem_write,
    input  running, halted, timed_out, done, cycle_count, retired_count, mem_write_count
  );

  modport slave (
    input  arm, clear, pc, cpu_state, mem_write,
    output running, halted, timed_out, done, cycle_count, retired_count, mem_write_count
  );
endinterface

// File: rtl/exec_monitor.sv
// Execution monitor: counts run cycles, retired instructions and memory writes, and
// flags halt (PC stuck in fetch) or timeout (run-cycle budget exhausted). Sticky until arm/clear.
module exec_monitor #(
  parameter int PC_WIDTH       = 16,
  parameter int STATE_WIDTH    = 3,
  parameter int FETCH_STATE    = 0,
  parameter int WB_STATE       = 4,
  parameter int HALT_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic         clock,
  input  logic         reset,
  exec_monitor_if.slave mon
);

  localparam int STB_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam logic [STB_W-1:0]       STB_MAX  = STB_W'(HALT_CYCLES - 1);
  localparam logic [63:0]            TO_LIM   = 64'(TIMEOUT_CYCLES - 1);
  localparam logic [STATE_WIDTH-1:0] FETCH_ST = STATE_WIDTH'(FETCH_STATE);
  localparam logic [STATE_WIDTH-1:0] WB_ST    = STATE_WIDTH'(WB_STATE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]   ret_q, ret_d;
  logic [CNT_WIDTH-1:0]   mw_q, mw_d;
  logic [STB_W-1:0]       stable_q, stable_d;
  logic [PC_WIDTH-1:0]    prev_pc_q, prev_pc_d;
  logic                   running_q, running_d;
  logic                   halted_q, halted_d;
  logic                   timed_out_q, timed_out_d;
  logic                   done_q, done_d;
  logic                   match_s;
  logic                   halt_hit_s;
  logic                   to_hit_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    logic [CNT_WIDTH-1:0] r;
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      r = v + CNT_WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Next-state and next-counter computation; clear beats arm, arm is ignored while running.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    mw_d       = mw_q;
    stable_d   = stable_q;
    prev_pc_d  = prev_pc_q;
    match_s    = (mon.pc == prev_pc_q) && (mon.cpu_state == FETCH_ST);
    halt_hit_s = match_s && (stable_q == STB_MAX);
    to_hit_s   = (64'(cyc_q) == TO_LIM);

    if (mon.clear) begin
      state_d   = ST_IDLE;
      cyc_d     = '0;
      ret_d     = '0;
      mw_d      = '0;
      stable_d  = '0;
      prev_pc_d = '1;
    end else if (mon.arm && (state_q != ST_RUN)) begin
      state_d   = ST_RUN;
      cyc_d     = '0;
      ret_d     = '0;
      mw_d      = '0;
      stable_d  = '0;
      prev_pc_d = '1;
    end else begin
      case (state_q)
        ST_RUN: begin
          prev_pc_d = mon.pc;
          cyc_d     = sat_inc(cyc_q, 1'b1);
          ret_d     = sat_inc(ret_q, mon.cpu_state == WB_ST);
          mw_d      = sat_inc(mw_q, mon.mem_write);
          if (!match_s) begin
            stable_d = '0;
          end else if (stable_q != STB_MAX) begin
            stable_d = stable_q + STB_W'(1);
          end else begin
            stable_d = stable_q;
          end
          // Counters above still advance on the edge that raises a flag.
          if (halt_hit_s) begin
            state_d = ST_HALTED;
          end else if (to_hit_s) begin
            state_d = ST_TIMEOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    running_d   = (state_d == ST_RUN);
    halted_d    = (state_d == ST_HALTED);
    timed_out_d = (state_d == ST_TIMEOUT);
    done_d      = (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
  end

  // State, counters and registered status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      ret_q       <= '0;
      mw_q        <= '0;
      stable_q    <= '0;
      prev_pc_q   <= '1;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      mw_q        <= mw_d;
      stable_q    <= stable_d;
      prev_pc_q   <= prev_pc_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
      done_q      <= done_d;
    end
  end

  assign mon.running         = running_q;
  assign mon.halted          = halted_q;
  assign mon.timed_out       = timed_out_q;
  assign mon.done            = done_q;
  assign mon.cycle_count     = cyc_q;
  assign mon.retired_count   = ret_q;
  assign mon.mem_write_count = mw_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Directed bench for exec_monitor: three instances share one stimulus stream
// (main config, 4-bit counters, and HALT_CYCLES=1 with TIMEOUT_CYCLES=1).
module tb_exec_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm;
  logic        clear;
  logic [15:0] pc;
  logic [2:0]  cpu_state;
  logic        mem_write;

  int n_checks;
  int n_fail;

  always #5 clock = ~clock;

  exec_monitor_if #(.PC_WIDTH(16), .STATE_WIDTH(3), .CNT_WIDTH(32)) if0 ();
  exec_monitor_if #(.PC_WIDTH(16), .STATE_WIDTH(3), .CNT_WIDTH(4))  if1 ();
  exec_monitor_if #(.PC_WIDTH(16), .STATE_WIDTH(3), .CNT_WIDTH(32)) if2 ();

  assign if0.arm = arm;   assign if0.clear = clear;   assign if0.pc = pc;
  assign if0.cpu_state = cpu_state;   assign if0.mem_write = mem_write;
  assign if1.arm = arm;   assign if1.clear = clear;   assign if1.pc = pc;
  assign if1.cpu_state = cpu_state;   assign if1.mem_write = mem_write;
  assign if2.arm = arm;   assign if2.clear = clear;   assign if2.pc = pc;
  assign if2.cpu_state = cpu_state;   assign if2.mem_write = mem_write;

  exec_monitor #(.PC_WIDTH(16), .STATE_WIDTH(3), .FETCH_STATE(0), .WB_STATE(4),
                 .HALT_CYCLES(5), .TIMEOUT_CYCLES(20), .CNT_WIDTH(32))
    u0 (.clock(clock), .reset(reset), .mon(if0));
  exec_monitor #(.PC_WIDTH(16), .STATE_WIDTH(3), .FETCH_STATE(0), .WB_STATE(4),
                 .HALT_CYCLES(5), .TIMEOUT_CYCLES(1000), .CNT_WIDTH(4))
    u1 (.clock(clock), .reset(reset), .mon(if1));
  exec_monitor #(.PC_WIDTH(16), .STATE_WIDTH(3), .FETCH_STATE(0), .WB_STATE(4),
                 .HALT_CYCLES(1), .TIMEOUT_CYCLES(1), .CNT_WIDTH(32))
    u2 (.clock(clock), .reset(reset), .mon(if2));

  typedef struct {
    logic        clr;
    logic        arm;
    logic [15:0] pc;
    logic [2:0]  st;
    logic        mw;
    logic        e_run;
    logic        e_halt;
    logic        e_to;
    int          e_cyc;
    int          e_ret;
    int          e_mw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic a, input logic [15:0] p,
                              input logic [2:0] s, input logic w, input logic r,
                              input logic h, input logic t, input int cy,
                              input int rt, input int m);
    vec_t v;
    v.clr = c; v.arm = a; v.pc = p; v.st = s; v.mw = w;
    v.e_run = r; v.e_halt = h; v.e_to = t; v.e_cyc = cy; v.e_ret = rt; v.e_mw = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_u0(input string name, input logic r, input logic h, input logic t,
                        input int cy, input int rt, input int m);
    check({name, "_running"},   64'(if0.running),         64'(r));
    check({name, "_halted"},    64'(if0.halted),          64'(h));
    check({name, "_timed_out"}, 64'(if0.timed_out),       64'(t));
    check({name, "_done"},      64'(if0.done),            64'(h | t));
    check({name, "_cycles"},    64'(if0.cycle_count),     64'(cy));
    check({name, "_retired"},   64'(if0.retired_count),   64'(rt));
    check({name, "_memwr"},     64'(if0.mem_write_count), 64'(m));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; arm = 1'b0; clear = 1'b0; pc = 16'h0000; cpu_state = 3'd0; mem_write = 1'b0;

    // Reset behaviour
    #3 reset = 1'b0;
    #1;
    chk_u0("rst_async", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    arm = 1'b1;
    step(); step();
    chk_u0("rst_hold_arm", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    arm = 1'b0; reset = 1'b1;
    step(); step();
    chk_u0("rst_release_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    arm = 1'b1;
    step();
    arm = 1'b0; pc = 16'h0020; cpu_state = 3'd4; mem_write = 1'b1;
    step(); step(); step();
    chk_u0("pre_reset_run", 1'b1, 1'b0, 1'b0, 3, 3, 3);
    reset = 1'b0;
    #1;
    chk_u0("rst_mid_run", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    reset = 1'b1; mem_write = 1'b0; cpu_state = 3'd0;
    step(); step(); step();
    chk_u0("rst_no_restart", 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Halt on stuck PC, then statistics with cpu_state cycling 0..4
    vecs.push_back(mk(1'b0, 1'b1, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0007, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0008, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 6, 0, 0));
    vecs.push_back(mk(1'b0, 1'b1, 16'h0010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0012, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0013, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0014, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, 1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0015, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1, 1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0016, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6, 1, 1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0017, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 7, 1, 1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0018, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1, 1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0019, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 9, 1, 2));
    vecs.push_back(mk(1'b0, 1'b0, 16'h001A, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 10, 2, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; arm = vecs[i].arm; pc = vecs[i].pc;
      cpu_state = vecs[i].st; mem_write = vecs[i].mw;
      step();
      chk_u0($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_halt, vecs[i].e_to,
             vecs[i].e_cyc, vecs[i].e_ret, vecs[i].e_mw);
    end

    // Match broken by a non-fetch state restarts the consecutive count
    clear = 1'b1; arm = 1'b0; mem_write = 1'b0;
    step();
    clear = 1'b0; arm = 1'b1;
    step();
    arm = 1'b0; pc = 16'h0009; cpu_state = 3'd0;
    repeat (4) step();
    cpu_state = 3'd2;
    step();
    cpu_state = 3'd0;
    repeat (4) step();
    chk_u0("brk_no_halt_yet", 1'b1, 1'b0, 1'b0, 9, 0, 0);
    step();
    chk_u0("brk_halt", 1'b0, 1'b1, 1'b0, 10, 0, 0);

    // Timeout with incrementing PC; arm in RUN ignored; 4-bit counter saturates
    clear = 1'b1;
    step();
    clear = 1'b0; arm = 1'b1;
    step();
    cpu_state = 3'd1;
    for (int i = 1; i <= 20; i++) begin
      pc  = 16'h0100 + 16'(i);
      arm = (i == 10) ? 1'b1 : 1'b0;
      step();
      if (i == 10) chk_u0("arm_in_run_ignored", 1'b1, 1'b0, 1'b0, 10, 0, 0);
      if (i == 15) check("sat_cycles_at15", 64'(if1.cycle_count), 64'd15);
      if (i == 19) chk_u0("to_pre", 1'b1, 1'b0, 1'b0, 19, 0, 0);
    end
    arm = 1'b0;
    chk_u0("timeout", 1'b0, 1'b0, 1'b1, 20, 0, 0);
    check("sat_cycles_stuck", 64'(if1.cycle_count), 64'd15);
    check("sat_still_running", 64'(if1.running), 64'd1);
    check("sat_no_timeout", 64'(if1.timed_out), 64'd0);

    // clear beats arm
    clear = 1'b1; arm = 1'b1;
    step();
    chk_u0("clear_over_arm", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    check("clear_over_arm_u1", 64'(if1.cycle_count), 64'd0);

    // First PC all ones matches immediately; halt beats simultaneous timeout
    clear = 1'b0; arm = 1'b1; pc = 16'hFFFF; cpu_state = 3'd0;
    step();
    check("u2_armed", 64'(if2.running), 64'd1);
    arm = 1'b0;
    step();
    check("u2_halted",    64'(if2.halted),      64'd1);
    check("u2_no_to",     64'(if2.timed_out),   64'd0);
    check("u2_done",      64'(if2.done),        64'd1);
    check("u2_cycles",    64'(if2.cycle_count), 64'd1);
    check("u2_stopped",   64'(if2.running),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
